hack_alu: RTL and testbench

- Registered 16-bit Hack-style ALU: two operands, six control bits (zx, nx, zy, ny, f, no) selecting all Hack arithmetic/logic functions.
- Combinational compute core followed by one pipeline register stage with valid handshake and zero/negative status flags.
- Sits in the CPU datapath between the register file/A-M mux and the writeback/jump-condition logic.

---
 rtl/hack_alu.sv | 86 ++++++++
 tb/tb_hack_alu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hack_alu.sv
// hack_alu: registered Hack-style ALU.
// Combinational core (zx/nx/zy/ny/f/no) feeding one output register stage
// with zero/negative status flags.
// Optional feature: define HACK_ALU_OVF_EN to add the registered signed
// overflow output ov.
//
// Handshake: in_valid has no ready partner; the block always accepts.
// Every rising edge with in_valid=1 captures one result, which appears with
// out_valid=1 after exactly one cycle. On an edge with in_valid=0, out_valid
// drops and out/zr/ng (and ov) keep their last values.
module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
`ifdef HACK_ALU_OVF_EN
  ,
  output logic             ov
`endif
);

  logic [WIDTH-1:0] x1, x2, y1, y2, sum, r, res;
  logic             res_zr;

  // Core evaluation: operand conditioning, function select, output inversion.
  always_comb begin
    x1     = zx ? '0 : a;
    x2     = nx ? ~x1 : x1;
    y1     = zy ? '0 : b;
    y2     = ny ? ~y1 : y1;
    sum    = x2 + y2;              // carry-out intentionally dropped
    r      = f ? sum : (x2 & y2);
    res    = no ? ~r : r;
    res_zr = (res == '0);
  end

  // Output register: capture on in_valid, otherwise hold data and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= res;
        zr  <= res_zr;
        ng  <= res[WIDTH-1];
      end
    end
  end

`ifdef HACK_ALU_OVF_EN
  logic res_ov;

  // Signed overflow of the adder: same-sign operands, different-sign sum.
  // Taken before the no inversion and forced low for the AND function.
  always_comb begin
    res_ov = f && (x2[WIDTH-1] == y2[WIDTH-1]) && (sum[WIDTH-1] != x2[WIDTH-1]);
  end

  // Overflow flag register, captured alongside out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov <= 1'b0;
    end else if (in_valid) begin
      ov <= res_ov;
    end
  end
`endif

endmodule

// File: tb/tb_hack_alu.sv
// tb_hack_alu: randomized and directed bench for hack_alu (WIDTH=16).
// Reference model works on integers: inversion as (2^16-1)-v, addition
// modulo 2^16, overflow from the signed sum range.
module tb_hack_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         zx, nx, zy, ny, f, no;
  logic         out_valid;
  logic [W-1:0] out;
  logic         zr, ng;
`ifdef HACK_ALU_OVF_EN
  logic         ov;
`endif

  hack_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .zx        (zx),
    .nx        (nx),
    .zy        (zy),
    .ny        (ny),
    .f         (f),
    .no        (no),
    .out_valid (out_valid),
    .out       (out),
    .zr        (zr),
    .ng        (ng)
`ifdef HACK_ALU_OVF_EN
    ,
    .ov        (ov)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Scoreboard: entries are {ov, zr, ng, out}
  logic [W+2:0] exp_q[$];
  logic [W+2:0] held;
  bit           pend_valid;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W+2:0] model(input int unsigned ta, input int unsigned tb_v,
                                         input logic [5:0] c);
    int unsigned mask = 32'd65535;
    int unsigned x, y, r;
    int          sx, sy, ssum;
    bit          o, z, n;
    x = c[5] ? 0 : ta;
    if (c[4]) x = mask - x;
    y = c[3] ? 0 : tb_v;
    if (c[2]) y = mask - y;
    if (c[1]) r = (x + y) % 65536;
    else      r = x & y;
    if (c[0]) r = mask - r;
    sx   = (x >= 32768) ? int'(x) - 65536 : int'(x);
    sy   = (y >= 32768) ? int'(y) - 65536 : int'(y);
    ssum = sx + sy;
    o    = c[1] && (ssum > 32767 || ssum < -32768);
    z    = (r == 0);
    n    = (r >= 32768);
    return {o, z, n, r[W-1:0]};
  endfunction

  task automatic check_outputs();
    check("out_valid", out_valid, pend_valid);
    if (pend_valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty got 0 entries exp 1");
      end else begin
        held = exp_q.pop_front();
      end
    end
    check("out", out, held[W-1:0]);
    check("zr", zr, held[W+1]);
    check("ng", ng, held[W]);
`ifdef HACK_ALU_OVF_EN
    check("ov", ov, held[W+2]);
`endif
  endtask

  // Driver tasks: inputs change on the falling edge only.
  task automatic drive(input bit v, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [5:0] c);
    in_valid = v;
    a = ta;
    b = tb_v;
    {zx, nx, zy, ny, f, no} = c;
    pend_valid = v;
    if (v) exp_q.push_back(model(ta, tb_v, c));
  endtask

  task automatic cycle(input bit v, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [5:0] c);
    @(negedge clk);
    check_outputs();
    drive(v, ta, tb_v, c);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom_range(0, 65535));
    endcase
  endfunction

  // Reset, directed sequences, random traffic, final report
  initial begin
    rst_n      = 1'b0;
    pend_valid = 1'b0;
    held       = '0;
    in_valid   = 1'b1;
    a          = 16'h1234;
    b          = 16'h5678;
    {zx, nx, zy, ny, f, no} = 6'b000010;

    // Reset held with in_valid high: nothing may be captured.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out", out, 16'h0000);
      check("rst_zr", zr, 1'b0);
      check("rst_ng", ng, 1'b0);
    end

    // Release reset; first capture happens on the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 16'h1100, 16'h1011, 6'b001101);   // ~x -> EEFF
    cycle(1, 16'h1100, 16'h1011, 6'b000010);   // x+y -> 2111
    cycle(1, 16'h1100, 16'h1011, 6'b000111);   // y-x -> FF11
    cycle(1, 16'h1100, 16'h1011, 6'b101010);   // 0
    cycle(1, 16'h1100, 16'h1011, 6'b111010);   // -1
    cycle(1, 16'h1100, 16'h1011, 6'b111111);   // 1
    cycle(1, 16'hFFFF, 16'h0001, 6'b000010);   // wrap to 0
    cycle(1, 16'h7FFF, 16'h0001, 6'b000010);   // 8000, signed overflow
    cycle(0, 16'h0000, 16'h0000, 6'b101010);   // hold
    cycle(0, 16'hAAAA, 16'h5555, 6'b000000);   // hold
    cycle(1, 16'h00F0, 16'h0F0F, 6'b010101);   // x|y
    cycle(1, 16'h0005, 16'h0003, 6'b010011);   // x-y
    cycle(1, 16'h8000, 16'h8000, 6'b000010);   // negative overflow

    // Asynchronous reset between clock edges discards the result.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_out", out, 16'h0000);
    check("async_zr", zr, 1'b0);
    check("async_ng", ng, 1'b0);
    exp_q.delete();
    held       = '0;
    pend_valid = 1'b0;
    in_valid   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic over all 64 control encodings with idle gaps.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, rand_operand(), rand_operand(),
            6'($urandom_range(0, 63)));
    end
    for (int c = 0; c < 64; c++) begin
      cycle(1, rand_operand(), rand_operand(), 6'(c));
    end
    cycle(0, 16'h0000, 16'h0000, 6'b000000);
    @(negedge clk);
    check_outputs();
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
